vec_alu_seq: RTL and testbench

VEC_ALU_SEQ -- requirements
Module: vec_alu_seq

---
 rtl/vec_alu_seq.sv | 125 ++++++++++++
 tb/tb_vec_alu_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_alu_seq.sv
// Sequential vector ALU: processes LANES elements per clock over a length-clamped vector.
// Optional macro VEC_ALU_SAT_EN makes add/mul saturate and sub clamp at zero.
module vec_alu_seq #(
    parameter int unsigned BITS  = 8,
    parameter int unsigned N     = 64,
    parameter int unsigned LANES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0][BITS-1:0]     a,
    input  logic [N-1:0][BITS-1:0]     b,
    input  logic [BITS-1:0]            len,
    input  logic [2:0]                 op,
    input  logic                       start,
    output logic [N-1:0][BITS-1:0]     res,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned CW = $clog2(N + LANES + 1);
    localparam int unsigned LW = (BITS > CW) ? BITS : CW;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [2:0]               op_q, op_d;
    logic [CW-1:0]            len_q, len_d;
    logic [CW-1:0]            idx_q, idx_d;
    logic [N-1:0][BITS-1:0]   res_q, res_d;

    logic [LW-1:0]            len_ext;
    logic [CW-1:0]            len_eff;
    logic [CW-1:0]            pos;

    function automatic logic [BITS-1:0] alu_f(input logic [2:0]      f_op,
                                               input logic [BITS-1:0] x,
                                               input logic [BITS-1:0] y);
        logic [BITS-1:0] r;
`ifdef VEC_ALU_SAT_EN
        logic [BITS:0]     sum;
        logic [2*BITS-1:0] prod;
        sum  = {1'b0, x} + {1'b0, y};
        prod = {{BITS{1'b0}}, x} * {{BITS{1'b0}}, y};
`endif
        r = '0;
        case (f_op)
`ifdef VEC_ALU_SAT_EN
            3'b000:  r = sum[BITS] ? '1 : sum[BITS-1:0];
            3'b001:  r = (x < y) ? '0 : x - y;
            3'b010:  r = (|prod[2*BITS-1:BITS]) ? '1 : prod[BITS-1:0];
`else
            3'b000:  r = x + y;
            3'b001:  r = x - y;
            3'b010:  r = x * y;
`endif
            3'b011:  r = x & y;
            3'b100:  r = x | y;
            3'b101:  r = x ^ y;
            3'b110:  r = (x < y) ? x : y;
            3'b111:  r = (x < y) ? y : x;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign len_ext = LW'(len);
    assign len_eff = (len_ext > LW'(N)) ? CW'(N) : CW'(len_ext);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        len_d   = len_q;
        idx_d   = idx_q;
        res_d   = res_q;
        pos     = '0;

        if (state_q == RUN) begin
            // Lanes past len_eff are skipped so the tail of res stays cleared.
            for (int unsigned k = 0; k < LANES; k++) begin
                pos = idx_q + CW'(k);
                if (pos < len_q) begin
                    res_d[pos[IW-1:0]] = alu_f(op_q, a[pos[IW-1:0]], b[pos[IW-1:0]]);
                end
            end
            idx_d = idx_q + CW'(LANES);
            if (idx_d >= len_q) begin
                state_d = DONE;
            end
        end

        if ((state_q != RUN) && start) begin
            op_d    = op;
            len_d   = len_eff;
            idx_d   = '0;
            res_d   = '0;
            state_d = (len_eff == '0) ? DONE : RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
        end
    end

    assign res  = res_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_vec_alu_seq.sv
// Scoreboard bench for vec_alu_seq: driver pushes model results, monitor pops on done.
// Model honours VEC_ALU_SAT_EN the same way the design build does.
module tb_vec_alu_seq;

    localparam int unsigned BITS  = 8;
    localparam int unsigned N     = 64;
    localparam int unsigned LANES = 4;

    typedef logic [N-1:0][BITS-1:0] vec_t;
    typedef struct {
        vec_t  res;
        int    cycles;
        string name;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    vec_t             a = '0;
    vec_t             b = '0;
    vec_t             res;
    logic [BITS-1:0]  len = '0;
    logic [2:0]       op = '0;
    logic             start = 1'b0;
    logic             busy;
    logic             done;

    exp_t q[$];
    vec_t last_res = '0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   busy_cnt = 0;
    bit   overlap  = 1'b0;

    always #5 clk = ~clk;

    vec_alu_seq #(
        .BITS (BITS),
        .N    (N),
        .LANES(LANES)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .len  (len),
        .op   (op),
        .start(start),
        .res  (res),
        .busy (busy),
        .done (done)
    );

    function automatic int ref_op(int o, int x, int y);
        int maxv = (1 << BITS) - 1;
        int modv = 1 << BITS;
        int r;
        case (o)
`ifdef VEC_ALU_SAT_EN
            0: begin r = x + y; if (r > maxv) r = maxv; end
            1: r = (x < y) ? 0 : x - y;
            2: begin r = x * y; if (r > maxv) r = maxv; end
`else
            0: r = (x + y) % modv;
            1: r = (x - y + modv) % modv;
            2: r = (x * y) % modv;
`endif
            3: r = x & y;
            4: r = x | y;
            5: r = x ^ y;
            6: r = (x < y) ? x : y;
            default: r = (x > y) ? x : y;
        endcase
        return r;
    endfunction

    function automatic exp_t model(int o, int l, vec_t va, vec_t vb, string nm);
        exp_t e;
        int   le = (l > N) ? N : l;
        e.res = '0;
        for (int i = 0; i < le; i++) begin
            e.res[i] = BITS'(ref_op(o, int'(va[i]), int'(vb[i])));
        end
        e.cycles = (le + LANES - 1) / LANES;
        e.name   = nm;
        return e;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = BITS'($urandom);
        return v;
    endfunction

    function automatic vec_t fill_vec(int val);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = BITS'(val);
        return v;
    endfunction

    task automatic cmp_int(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_vec(string nm, vec_t act, vec_t exp);
        n_checks++;
        if (act !== exp) begin
            int idx = 0;
            n_fail++;
            for (int i = N - 1; i >= 0; i--) if (act[i] !== exp[i]) idx = i;
            $display("FAIL %s: res[%0d]=%0d, expected %0d", nm, idx, act[idx], exp[idx]);
        end
    endtask

    // Monitor: counts RUN cycles and checks each finished operation against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt = 0;
                overlap  = 1'b0;
            end else begin
                if (busy && done) overlap = 1'b1;
                if (busy) busy_cnt++;
                if (done && q.size() > 0) begin
                    e = q.pop_front();
                    cmp_vec({e.name, " res"}, res, e.res);
                    cmp_int({e.name, " run cycles"}, busy_cnt, e.cycles);
                    cmp_int({e.name, " busy&done"}, int'(overlap), 0);
                    busy_cnt = 0;
                    overlap  = 1'b0;
                end
            end
        end
    end

    task automatic wait_drain(string nm);
        for (int c = 0; c < 300 && q.size() > 0; c++) @(negedge clk);
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: %0d results pending, expected 0", nm, q.size());
            q.delete();
        end
    endtask

    task automatic run_op(int o, int l, vec_t va, vec_t vb, string nm, int glitch);
        exp_t e;
        @(negedge clk);
        a     = va;
        b     = vb;
        op    = o[2:0];
        len   = l[BITS-1:0];
        start = 1'b1;
        @(posedge clk);
        e = model(o, l, va, vb, nm);
        q.push_back(e);
        last_res = e.res;
        #1 start = 1'b0;
        if (glitch > 0) begin
            repeat (glitch) @(negedge clk);
            op    = ~o[2:0];
            len   = 8'd3;
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            op  = o[2:0];
            len = l[BITS-1:0];
        end
        wait_drain(nm);
        repeat (3) @(negedge clk);
        cmp_vec({nm, " hold"}, res, last_res);
        cmp_int({nm, " hold done"}, int'(done), 1);
        cmp_int({nm, " hold busy"}, int'(busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t ramp, va, vb;
        exp_t e;

        #12;
        cmp_vec("reset res", res, '0);
        cmp_int("reset busy", int'(busy), 0);
        cmp_int("reset done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < N; i++) ramp[i] = BITS'(i);
        run_op(0, 6, ramp, fill_vec(10), "partial_add", 0);
        run_op(0, 4, fill_vec(200), fill_vec(100), "add_200_100", 0);
        run_op(1, 8, fill_vec(5), fill_vec(9), "sub_5_9", 0);
        run_op(6, 8, fill_vec(5), fill_vec(9), "min_5_9", 0);
        run_op(0, 0, rand_vec(), rand_vec(), "len0", 0);
        run_op(2, 200, rand_vec(), rand_vec(), "len200_mul", 0);
        run_op(5, 64, rand_vec(), rand_vec(), "start_in_run", 3);
        run_op(4, 4, rand_vec(), rand_vec(), "restart_clear", 0);

        // Abort mid-RUN: rst in the second RUN cycle, then start on the first edge after release.
        va = rand_vec() | fill_vec(1);
        vb = rand_vec();
        @(negedge clk);
        a = va; b = vb; op = 3'b100; len = 8'd64; start = 1'b1;
        @(posedge clk);
        e = model(4, 64, va, vb, "aborted");
        q.push_back(e);
        #1 start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        cmp_vec("abort res", res, '0);
        cmp_int("abort busy", int'(busy), 0);
        cmp_int("abort done", int'(done), 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        cmp_vec("abort res idle", res, '0);
        cmp_int("abort done idle", int'(done), 0);
        rst = 1'b0;
        run_op(0, 10, rand_vec(), rand_vec(), "after_reset", 0);

        for (int t = 0; t < 20; t++) begin
            run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 80)),
                   rand_vec(), rand_vec(), $sformatf("rand%0d", t), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
